// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Brief    : Shared constants for the multi-channel PWM block
// Revision : 1.0
// ============================================================================
package pwm_pkg;

    localparam int   c_DEFAULT_CW     = 20;
    localparam int   c_DEFAULT_PERIOD = 100;
    localparam int   c_MIN_PERIOD     = 2;

    localparam logic c_DIR_UP         = 1'b0;
    localparam logic c_DIR_DOWN       = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pwm_compare.sv
`default_nettype none
// ============================================================================
// Module   : pwm_compare
// Brief    : One PWM channel: duty shadow register and registered comparator
// Revision : 1.0
// ============================================================================
module pwm_compare
    import pwm_pkg::*;
#(
    parameter int CW = c_DEFAULT_CW
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_duty,
    input  logic [CW-1:0] i_cnt,
    input  logic          i_active,
    output logic          o_pwm
);

    logic [CW-1:0] r_duty_sh;
    logic          r_pwm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty_sh <= '0;
            r_pwm     <= 1'b0;
        end else begin
            if (i_load) begin
                r_duty_sh <= i_duty;
            end
            // Compare against the shadow only, so mid-period duty writes are invisible
            r_pwm <= i_active & (i_cnt < r_duty_sh);
        end
    end

    assign o_pwm = r_pwm;

endmodule
`default_nettype wire

// File: rtl/pwm_multi_ch.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi_ch
// Brief    : Multi-channel PWM with shared counter and period/duty shadowing.
//            Define PWM_CENTER_ALIGN_EN for up/down (center-aligned) counting.
// Revision : 1.0
// ============================================================================
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int CH             = 4,
    parameter int CW             = c_DEFAULT_CW,
    parameter int DEFAULT_PERIOD = c_DEFAULT_PERIOD
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CW-1:0]    period,
    input  logic [CH*CW-1:0] duty,
    output logic [CH-1:0]    pwm_wave,
    output logic             period_start
);

    localparam logic [CW-1:0] c_ONE     = CW'(1);
    localparam logic [CW-1:0] c_MIN_PER = CW'(c_MIN_PERIOD);
    localparam logic [CW-1:0] c_RST_PER =
        CW'((DEFAULT_PERIOD < c_MIN_PERIOD) ? c_MIN_PERIOD : DEFAULT_PERIOD);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_per_sh;
    logic          r_run;
    logic          r_period_start;

    logic [CW-1:0] w_cnt_next;
    logic [CW-1:0] w_per_in;
    logic          w_active;
    logic          w_start;
    logic          w_boundary;
    logic          w_load;

    assign w_per_in = (period < c_MIN_PER) ? c_MIN_PER : period;
    assign w_active = en & r_run;
    assign w_start  = en & ~r_run;
    // Shadows track the inputs while idle and otherwise refresh only at a boundary
    assign w_load   = ~w_active | w_boundary;

`ifdef PWM_CENTER_ALIGN_EN
    logic r_dir;
    logic w_dir_next;

    always_comb begin
        w_dir_next = r_dir;
        w_cnt_next = r_cnt + c_ONE;
        if (r_dir == c_DIR_UP) begin
            if (r_cnt == r_per_sh - c_ONE) begin
                w_cnt_next = r_cnt - c_ONE;
                w_dir_next = c_DIR_DOWN;
            end
        end else begin
            w_cnt_next = r_cnt - c_ONE;
        end
        // Reaching zero is the bottom turnaround; with per_sh==2 it happens from the up phase
        w_boundary = (w_cnt_next == '0);
        if (w_boundary) begin
            w_dir_next = c_DIR_UP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir <= c_DIR_UP;
        end else if (w_active) begin
            r_dir <= w_dir_next;
        end else begin
            r_dir <= c_DIR_UP;
        end
    end
`else
    always_comb begin
        w_boundary = (r_cnt == r_per_sh - c_ONE);
        w_cnt_next = w_boundary ? '0 : (r_cnt + c_ONE);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt          <= '0;
            r_per_sh       <= c_RST_PER;
            r_run          <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_run          <= en;
            r_period_start <= w_start | (w_active & w_boundary);
            r_cnt          <= w_active ? w_cnt_next : '0;
            if (w_load) begin
                r_per_sh <= w_per_in;
            end
        end
    end

    assign period_start = r_period_start;

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        pwm_compare #(
            .CW       (CW)
        ) u_cmp (
            .clk      (clk),
            .rst      (rst),
            .i_load   (w_load),
            .i_duty   (duty[gi*CW +: CW]),
            .i_cnt    (r_cnt),
            .i_active (w_active),
            .o_pwm    (pwm_wave[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_ch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi_ch
// Brief    : Self-checking bench for pwm_multi_ch against a period-phase model
// Revision : 1.0
// ============================================================================
module tb_pwm_multi_ch;

    localparam int c_CH      = 4;
    localparam int c_CW      = 20;
    localparam int c_DEF_PER = 100;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic [c_CW-1:0]      period;
    logic [c_CH*c_CW-1:0] duty;
    logic [c_CH-1:0]      pwm_wave;
    logic                 period_start;

    pwm_multi_ch #(
        .CH             (c_CH),
        .CW             (c_CW),
        .DEFAULT_PERIOD (c_DEF_PER)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .period       (period),
        .duty         (duty),
        .pwm_wave     (pwm_wave),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: position within the period plus shadowed settings
    bit            m_run;
    int            m_k;
    int            m_per;
    int            m_duty [c_CH];
    logic [c_CH-1:0] exp_pwm;
    logic          exp_ps;

    int hi [c_CH];
    int nps;
    int cyc;
    int last_ps;
    int gap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at time %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampp(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    function automatic int plen(input int p);
`ifdef PWM_CENTER_ALIGN_EN
        return 2 * (p - 1);
`else
        return p;
`endif
    endfunction

    function automatic int cnt_at(input int k, input int p);
        return (k < p) ? k : 2 * (p - 1) - k;
    endfunction

    task automatic model_reset();
        m_run   = 1'b0;
        m_k     = 0;
        m_per   = clampp(c_DEF_PER);
        for (int i = 0; i < c_CH; i++) m_duty[i] = 0;
        exp_pwm = '0;
        exp_ps  = 1'b0;
    endtask

    task automatic model_load();
        m_per = clampp(int'(period));
        for (int i = 0; i < c_CH; i++) m_duty[i] = int'(duty[i*c_CW +: c_CW]);
    endtask

    task automatic model_step();
        int c;
        if (rst) begin
            model_reset();
        end else if (!en) begin
            m_run = 1'b0; m_k = 0; model_load();
            exp_pwm = '0; exp_ps = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1; m_k = 0; model_load();
            exp_pwm = '0; exp_ps = 1'b1;
        end else begin
            c = cnt_at(m_k, m_per);
            for (int i = 0; i < c_CH; i++) exp_pwm[i] = (c < m_duty[i]);
            m_k++;
            if (m_k == plen(m_per)) begin
                m_k = 0; model_load(); exp_ps = 1'b1;
            end else begin
                exp_ps = 1'b0;
            end
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < c_CH; i++) hi[i] = 0;
        nps = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check("pwm_wave", 32'(pwm_wave), 32'(exp_pwm));
        check("period_start", 32'(period_start), 32'(exp_ps));
        for (int i = 0; i < c_CH; i++) if (pwm_wave[i]) hi[i]++;
        if (period_start) begin
            nps++;
            gap     = cyc - last_ps;
            last_ps = cyc;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_duty(input int ch, input int v);
        duty[ch*c_CW +: c_CW] = c_CW'(v);
    endtask

    task automatic wait_k(input int k, input string tag);
        int t = 0;
        while (!(m_run && m_k == k) && t < 60) begin
            tick();
            t++;
        end
        if (t >= 60) check(tag, 32'(m_k), 32'(k));
    endtask

    task automatic wait_ps(input string tag);
        int t = 0;
        do begin
            tick();
            t++;
        end while (!period_start && t < 60);
        if (t >= 60) check(tag, 32'(period_start), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b0; period = 10; duty = '0;
        cyc = 0; last_ps = 0; gap = 0;
        model_reset();
        clear_counts();
        @(negedge clk);
        check("reset_pwm", 32'(pwm_wave), 32'd0);
        check("reset_ps", 32'(period_start), 32'd0);
        ticks(2);
        rst = 1'b0;
        ticks(2);

        // Case 1: mixed duties including 0 and >= period
        period = 10;
        set_duty(0, 0); set_duty(1, 3); set_duty(2, 10); set_duty(3, 15);
        en = 1'b1;
        tick();
        check("start_ps", 32'(period_start), 32'd1);
        ticks(25);
        clear_counts();
        ticks(20);
`ifndef PWM_CENTER_ALIGN_EN
        check("c1_ch0_high", 32'(hi[0]), 32'd0);
        check("c1_ch1_high", 32'(hi[1]), 32'd6);
        check("c1_ch2_high", 32'(hi[2]), 32'd20);
        check("c1_ch3_high", 32'(hi[3]), 32'd20);
        check("c1_ps_count", 32'(nps), 32'd2);
        check("c1_ps_gap", 32'(gap), 32'd10);
`endif

        // Case 2: duty write mid-period waits for the boundary
        set_duty(0, 5);
        wait_ps("c2_sync");
        wait_k(4, "c2_wait");
        set_duty(0, 2);
        clear_counts();
        ticks(6);
`ifndef PWM_CENTER_ALIGN_EN
        check("c2_rest_of_period", 32'(hi[0]), 32'd1);
        clear_counts();
        ticks(10);
        check("c2_next_period", 32'(hi[0]), 32'd2);
`endif

        // Case 3: period write mid-period
        wait_k(3, "c3_wait");
        period = 20;
        wait_ps("c3_ps1");
        wait_ps("c3_ps2");
`ifndef PWM_CENTER_ALIGN_EN
        check("c3_new_gap", 32'(gap), 32'd20);
`endif

        // Case 4: period 0 and 1 are clamped to 2
        for (int p = 0; p < 2; p++) begin
            period = c_CW'(p);
            for (int i = 0; i < c_CH; i++) set_duty(i, 1);
            ticks(25);
            clear_counts();
            ticks(10);
`ifndef PWM_CENTER_ALIGN_EN
            check("c4_ps_count", 32'(nps), 32'd5);
            check("c4_half_wave", 32'(hi[0]), 32'd5);
`endif
        end

        // Case 5: asynchronous reset mid-period
        period = 10;
        for (int i = 0; i < c_CH; i++) set_duty(i, 15);
        wait_ps("c5_sync");
        wait_k(6, "c5_wait");
        check("c5_before_rst", 32'(pwm_wave), 32'hF);
        #2 rst = 1'b1;
        #1;
        check("c5_async_pwm", 32'(pwm_wave), 32'd0);
        check("c5_async_ps", 32'(period_start), 32'd0);
        model_reset();
        @(negedge clk);
        ticks(2);
        rst = 1'b0;
        tick();
        check("c5_ps_after_rst", 32'(period_start), 32'd1);
        ticks(12);

`ifdef PWM_CENTER_ALIGN_EN
        // Case 6: center-aligned period and bottom-only duty load
        period = 6; set_duty(0, 2);
        ticks(30);
        clear_counts();
        wait_ps("c6_sync");
        clear_counts();
        ticks(20);
        check("c6_ps_gap", 32'(gap), 32'd10);
        check("c6_high", 32'(hi[0]), 32'd6);
        wait_k(3, "c6_wait");
        set_duty(0, 4);
        ticks(30);
`endif

        // Randomized traffic: en toggles, period and duty changes at random times
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 14) == 0) period = c_CW'($urandom_range(0, 16));
            for (int i = 0; i < c_CH; i++)
                if ($urandom_range(0, 7) == 0) set_duty(i, int'($urandom_range(0, 18)));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_multi_ch.md
PWM_MULTI_CH -- requirements
Module: pwm_multi_ch

Interface
REQ-001 The block SHALL have parameter CH, default 4, giving the number of PWM channels (1..16).
REQ-002 The block SHALL have parameter CW, default 20, giving the width of the counter, period and duty values.
REQ-003 The block SHALL have parameter DEFAULT_PERIOD, default 100, giving the period loaded at reset.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the reset; asynchronous and active-high.
REQ-006 The block SHALL have port en, input, 1 bit, the counter run enable.
REQ-007 The block SHALL have port period, input, CW bits, the PWM period in clk cycles.
REQ-008 The block SHALL have port duty, input, CH*CW bits, the flattened duty values; channel i occupies bits [i*CW +: CW].
REQ-009 The block SHALL have port pwm_wave, output, CH bits, one PWM output per channel.
REQ-010 The block SHALL have port period_start, output, 1 bit, a one-cycle pulse marking each period boundary.

Function
REQ-011 The block SHALL run one shared counter cnt of CW bits and keep shadow registers per_sh and duty_sh[i].
REQ-012 The block SHALL clamp per_sh to 2 whenever it captures a period value of 0 or 1.
REQ-013 In edge-aligned mode, cnt SHALL count 0..per_sh-1 and then wrap to 0, giving per_sh cycles per period.
REQ-014 On the wrap cycle (cnt==per_sh-1, en=1), the block SHALL load period and every duty into the shadows for the next period.
REQ-015 On the wrap cycle, period_start SHALL be asserted on the following cycle, aligned with cnt==0.
REQ-016 The block SHALL register pwm_wave[i] as (cnt < duty_sh[i]), one cycle after cnt.
REQ-017 duty_sh[i]==0 SHALL give a constant-low output; duty_sh[i]>=per_sh SHALL give a constant-high output with no glitch at the wrap.
REQ-018 Input changes mid-period SHALL have no effect until the next boundary; the shadows are the only values the comparators use.
REQ-019 While en=0, the block SHALL:
- hold cnt at 0;
- hold pwm_wave and period_start at 0;
- load the shadows from the inputs every cycle.
REQ-020 On the first cycle with en=1 after en=0, period_start SHALL pulse and counting SHALL start from 0 using the shadow values.
REQ-021 Deasserting en mid-period SHALL abort the period immediately, with no completion of the current period.

Reset
REQ-022 While rst=1, the block SHALL force cnt=0, per_sh=DEFAULT_PERIOD (clamped per REQ-012), all duty_sh=0, pwm_wave=0 and period_start=0.
REQ-023 After rst deasserts, the first clk edge with en=1 SHALL behave as the en rising case of REQ-020.
REQ-024 Asserting rst mid-period SHALL zero all outputs asynchronously, without waiting for a clk edge.

Configuration
REQ-025 The macro PWM_CENTER_ALIGN_EN, when defined, SHALL compile in center-aligned mode as follows:
- cnt counts up 0..per_sh-1, then down to 0;
- each period is 2*(per_sh-1) cycles long;
- the shadows load and period_start pulses only at the bottom turnaround (cnt==0 after counting down);
- pwm_wave[i] is (cnt < duty_sh[i]), giving waveforms symmetric about the bottom.
REQ-026 Without PWM_CENTER_ALIGN_EN, the block SHALL contain only edge-aligned logic and no direction register.

Structure
REQ-027 The package pwm_pkg SHALL hold the default CW, the DEFAULT_PERIOD value, the minimum-period constant (2), and the counter direction encoding (UP/DOWN).
REQ-028 The per-channel shadow register plus registered comparator SHALL be the sub-module pwm_compare, instantiated CH times by a generate loop.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- Case 1: CH=4, period=10, duty={0,3,10,15}, en=1 -> ch0 low; ch1 high 3 of 10 cycles; ch2 and ch3 high constantly; period_start every 10 cycles.
- Case 2: period=10, duty0=5; set duty0=2 at cnt==4 -> current period keeps 5 high cycles; next period shows 2.
- Case 3: change period 10->20 mid-period -> the current period ends at 10 cycles, then period_start spacing is 20.
- Case 4: period=0 and period=1 -> both treated as 2; period_start every 2 cycles; duty=1 gives a 50% wave.
- Case 5: assert rst between clk edges at cnt==6 -> outputs 0 immediately; after release with en=1, period_start pulses on the first edge.
- Case 6: with PWM_CENTER_ALIGN_EN, period=6, duty=2 -> 10-cycle period with the high window centered on cnt==0; a duty change loads only at the bottom.
